// File: rtl/frame_buf_ring.sv
// Ring of NUM_BUFS frame slots in external memory: the writer fills whole frames and the
// reader consumes them oldest-first. Addresses and active-low commands only; no data path.
module frame_buf_ring #(
    parameter int ADDR_WIDTH = 29,
    parameter int BASE_ADDR  = 2,
    parameter int BUF_SIZE   = 307200,
    parameter int NUM_BUFS   = 3,
    parameter int SLOT_W     = 3,
    parameter bit DROP_MODE  = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en_in,
    input  logic                  rd_en_in,
    input  logic                  wr_rdy,
    input  logic                  rd_rdy,
    output logic                  wr_en,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [SLOT_W-1:0]     wr_slot,
    output logic [SLOT_W-1:0]     rd_slot,
    output logic [SLOT_W-1:0]     frames_avail,
    output logic                  full,
    output logic                  empty,
    output logic                  wr_frame_done,
    output logic                  rd_frame_done,
    output logic                  frame_drop
);
    localparam int OFF_W = (BUF_SIZE > 1) ? $clog2(BUF_SIZE) : 1;
    localparam logic [OFF_W-1:0]  LAST_OFF  = OFF_W'(BUF_SIZE - 1);
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_BUFS - 1);
    localparam logic [SLOT_W:0]   NBUF      = (SLOT_W + 1)'(NUM_BUFS);

    typedef enum logic {W_IDLE, W_FILL} wstate_t;
    typedef enum logic {R_IDLE, R_READ} rstate_t;

    wstate_t           wstate;
    rstate_t           rstate;
    logic [OFF_W-1:0]  wr_off, rd_off;
    logic [SLOT_W-1:0] head;
    logic [SLOT_W-1:0] avail_nxt;
    logic              rd_busy, busy_nxt;
    logic              slot_free, wr_beat, rd_beat, wr_last, rd_last;
    logic              wr_start, wr_drop, rd_start;

    function automatic logic [ADDR_WIDTH-1:0] slot_base(input logic [SLOT_W-1:0] s);
        return ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'(s) * ADDR_WIDTH'(BUF_SIZE);
    endfunction

    function automatic logic [SLOT_W-1:0] slot_inc(input logic [SLOT_W-1:0] s);
        return (s == LAST_SLOT) ? '0 : s + SLOT_W'(1);
    endfunction

    function automatic logic [SLOT_W-1:0] slot_dec(input logic [SLOT_W-1:0] s);
        return (s == '0) ? LAST_SLOT : s - SLOT_W'(1);
    endfunction

    // Every decision below looks at pre-edge counts, so a slot freed this edge is usable next cycle.
    assign rd_busy   = (rstate == R_READ);
    assign slot_free = ({1'b0, frames_avail} + {{SLOT_W{1'b0}}, rd_busy}) < NBUF;
    assign wr_beat   = (wstate == W_FILL) && !wr_en && wr_rdy;
    assign rd_beat   = rd_busy && !rd_en && rd_rdy;
    assign wr_last   = wr_beat && (wr_off == LAST_OFF);
    assign rd_last   = rd_beat && (rd_off == LAST_OFF);
    assign wr_start  = (wstate == W_IDLE) && !wr_en_in && slot_free;
    assign wr_drop   = (wstate == W_IDLE) && !wr_en_in && !slot_free && DROP_MODE;
    assign rd_start  = (rstate == R_IDLE) && !rd_en_in && (frames_avail != '0);

    always_comb begin
        avail_nxt = frames_avail;
        if (wr_last)  avail_nxt = avail_nxt + SLOT_W'(1);
        if (wr_drop)  avail_nxt = avail_nxt - SLOT_W'(1);
        if (rd_start) avail_nxt = avail_nxt - SLOT_W'(1);
        busy_nxt = rd_start | (rd_busy & ~rd_last);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frames_avail <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
        end else begin
            frames_avail <= avail_nxt;
            full         <= ({1'b0, avail_nxt} + {{SLOT_W{1'b0}}, busy_nxt}) == NBUF;
            empty        <= (avail_nxt == '0);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wstate        <= W_IDLE;
            wr_en         <= 1'b1;
            wr_addr       <= ADDR_WIDTH'(BASE_ADDR);
            wr_off        <= '0;
            wr_slot       <= '0;
            wr_frame_done <= 1'b0;
            frame_drop    <= 1'b0;
        end else begin
            wr_frame_done <= 1'b0;
            frame_drop    <= 1'b0;
            if (wstate == W_IDLE) begin
                if (wr_start || wr_drop) begin
                    // A drop rewinds onto the newest pending frame; the reader owns the oldest.
                    wstate  <= W_FILL;
                    wr_en   <= 1'b0;
                    wr_off  <= '0;
                    wr_addr <= slot_base(wr_drop ? slot_dec(wr_slot) : wr_slot);
                    if (wr_drop) begin
                        wr_slot    <= slot_dec(wr_slot);
                        frame_drop <= 1'b1;
                    end
                end
            end else if (wr_last) begin
                wstate        <= W_IDLE;
                wr_en         <= 1'b1;
                wr_frame_done <= 1'b1;
                wr_slot       <= slot_inc(wr_slot);
            end else begin
                wr_en <= wr_en_in;
                if (wr_beat) begin
                    wr_addr <= wr_addr + ADDR_WIDTH'(1);
                    wr_off  <= wr_off + OFF_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rstate        <= R_IDLE;
            rd_en         <= 1'b1;
            rd_addr       <= ADDR_WIDTH'(BASE_ADDR);
            rd_off        <= '0;
            rd_slot       <= '0;
            head          <= '0;
            rd_frame_done <= 1'b0;
        end else begin
            rd_frame_done <= 1'b0;
            if (rstate == R_IDLE) begin
                if (rd_start) begin
                    rstate  <= R_READ;
                    rd_en   <= 1'b0;
                    rd_off  <= '0;
                    rd_slot <= head;
                    rd_addr <= slot_base(head);
                    head    <= slot_inc(head);
                end
            end else if (rd_last) begin
                rstate        <= R_IDLE;
                rd_en         <= 1'b1;
                rd_frame_done <= 1'b1;
            end else begin
                rd_en <= rd_en_in;
                if (rd_beat) begin
                    rd_addr <= rd_addr + ADDR_WIDTH'(1);
                    rd_off  <= rd_off + OFF_W'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_frame_buf_ring.sv
// Bench for frame_buf_ring: a stall-mode and a drop-mode instance share stimulus and are checked
// every cycle against a ring model (head + pending count), plus a vector table and directed cases.
module tb_frame_buf_ring;
    localparam int AW   = 16;
    localparam int BASE = 2;
    localparam int BS   = 4;
    localparam int N    = 3;
    localparam int SW   = 3;

    logic clk = 1'b0;
    logic reset;
    logic wi, ri, wy, ry;
    logic [1:0]         w_en, r_en, full_o, empty_o, wdone, rdone, fdrop;
    logic [1:0][AW-1:0] waddr, raddr;
    logic [1:0][SW-1:0] wslot, rslot, favail;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        frame_buf_ring #(
            .ADDR_WIDTH(AW), .BASE_ADDR(BASE), .BUF_SIZE(BS),
            .NUM_BUFS(N), .SLOT_W(SW), .DROP_MODE(g == 1)
        ) u_dut (
            .clk(clk), .reset(reset),
            .wr_en_in(wi), .rd_en_in(ri), .wr_rdy(wy), .rd_rdy(ry),
            .wr_en(w_en[g]), .rd_en(r_en[g]),
            .wr_addr(waddr[g]), .rd_addr(raddr[g]),
            .wr_slot(wslot[g]), .rd_slot(rslot[g]),
            .frames_avail(favail[g]), .full(full_o[g]), .empty(empty_o[g]),
            .wr_frame_done(wdone[g]), .rd_frame_done(rdone[g]), .frame_drop(fdrop[g])
        );
    end

    // Reference model: pending frames are cnt consecutive slots starting at head.
    typedef struct {
        int wfill, wen, woff, wslot, waddr;
        int rbusy, ren, roff, rslot, raddr;
        int head, cnt, wdone, rdone, drop;
    } mst_t;

    mst_t ms0, ms1;

    function automatic int base(int s);
        return BASE + s * BS;
    endfunction

    function automatic mst_t m_reset();
        mst_t n;
        n.wfill = 0; n.wen = 1; n.woff = 0; n.wslot = 0; n.waddr = BASE;
        n.rbusy = 0; n.ren = 1; n.roff = 0; n.rslot = 0; n.raddr = BASE;
        n.head = 0; n.cnt = 0; n.wdone = 0; n.rdone = 0; n.drop = 0;
        return n;
    endfunction

    function automatic mst_t step(mst_t s, bit dm, bit i_w, bit i_r, bit i_wy, bit i_ry);
        mst_t n = s;
        int free_slots = N - s.cnt - s.rbusy;
        bit wbeat = (s.wfill != 0) && (s.wen == 0) && i_wy;
        bit rbeat = (s.rbusy != 0) && (s.ren == 0) && i_ry;
        n.wdone = 0; n.rdone = 0; n.drop = 0;
        if (s.wfill == 0) begin
            if (!i_w && (free_slots > 0 || dm)) begin
                if (free_slots == 0) begin
                    n.drop  = 1;
                    n.cnt   = s.cnt - 1;
                    n.wslot = (s.head + s.cnt - 1) % N;
                end
                n.wfill = 1; n.wen = 0; n.woff = 0; n.waddr = base(n.wslot);
            end
        end else if (wbeat && s.woff == BS - 1) begin
            n.wfill = 0; n.wen = 1; n.wdone = 1;
            n.cnt   = s.cnt + 1;
            n.wslot = (s.wslot + 1) % N;
        end else begin
            n.wen = i_w;
            if (wbeat) begin
                n.woff  = s.woff + 1;
                n.waddr = s.waddr + 1;
            end
        end
        if (s.rbusy == 0) begin
            if (!i_r && s.cnt > 0) begin
                n.rbusy = 1; n.ren = 0; n.roff = 0;
                n.rslot = s.head; n.raddr = base(s.head);
                n.head  = (s.head + 1) % N;
                n.cnt   = n.cnt - 1;
            end
        end else if (rbeat && s.roff == BS - 1) begin
            n.rbusy = 0; n.ren = 1; n.rdone = 1;
        end else begin
            n.ren = i_r;
            if (rbeat) begin
                n.roff  = s.roff + 1;
                n.raddr = s.raddr + 1;
            end
        end
        return n;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            ms0 <= m_reset();
            ms1 <= m_reset();
        end else begin
            ms0 <= step(ms0, 1'b0, wi, ri, wy, ry);
            ms1 <= step(ms1, 1'b1, wi, ri, wy, ry);
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic cmp(input int m, input mst_t s);
        string p = (m == 1) ? "d1_" : "d0_";
        chk({p, "wr_en"},         32'(w_en[m]),    s.wen);
        chk({p, "rd_en"},         32'(r_en[m]),    s.ren);
        chk({p, "wr_addr"},       32'(waddr[m]),   s.waddr);
        chk({p, "rd_addr"},       32'(raddr[m]),   s.raddr);
        chk({p, "wr_slot"},       32'(wslot[m]),   s.wslot);
        chk({p, "rd_slot"},       32'(rslot[m]),   s.rslot);
        chk({p, "frames_avail"},  32'(favail[m]),  s.cnt);
        chk({p, "full"},          32'(full_o[m]),  (s.cnt + s.rbusy == N) ? 1 : 0);
        chk({p, "empty"},         32'(empty_o[m]), (s.cnt == 0) ? 1 : 0);
        chk({p, "wr_frame_done"}, 32'(wdone[m]),   s.wdone);
        chk({p, "rd_frame_done"}, 32'(rdone[m]),   s.rdone);
        chk({p, "frame_drop"},    32'(fdrop[m]),   s.drop);
    endtask

    task automatic tick();
        @(negedge clk);
        cmp(0, ms0);
        cmp(1, ms1);
    endtask

    task automatic do_reset();
        reset = 1'b1; wi = 1'b1; ri = 1'b1; wy = 1'b0; ry = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    // Drive one write request until stall-mode instance reports frame done (bounded).
    task automatic write_frame(output int last_addr);
        bit seen = 1'b0;
        wi = 1'b0; wy = 1'b1;
        last_addr = -1;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (wdone[0]) begin
                seen = 1'b1;
                last_addr = int'(waddr[0]);
                break;
            end
        end
        wi = 1'b1;
        chk("write_frame_done_seen", 32'(seen), 1);
    endtask

    typedef struct {
        bit i_w, i_r, i_wy, i_ry;
        bit wen; int wa; bit wd;
        bit ren; int ra; bit rd;
        int fa; bit emp;
    } vec_t;

    vec_t tv[11];

    initial begin
        int last, beats, maxa, prev;
        bit seen;
        reset = 1'b1; wi = 1'b1; ri = 1'b1; wy = 1'b0; ry = 1'b0;
        tick();
        tick();
        chk("rst_wr_en", 32'(w_en[0]), 1);
        chk("rst_rd_en", 32'(r_en[0]), 1);
        chk("rst_wr_addr", 32'(waddr[0]), 2);
        chk("rst_rd_addr", 32'(raddr[0]), 2);
        chk("rst_full", 32'(full_o[1]), 0);
        chk("rst_empty", 32'(empty_o[1]), 1);
        reset = 1'b0;

        // single frame write then read, from reset
        tv[0]  = '{0,1,1,0, 0,2,0, 1,2,0, 0,1};
        tv[1]  = '{0,1,1,0, 0,3,0, 1,2,0, 0,1};
        tv[2]  = '{0,1,1,0, 0,4,0, 1,2,0, 0,1};
        tv[3]  = '{0,1,1,0, 0,5,0, 1,2,0, 0,1};
        tv[4]  = '{0,1,1,0, 1,5,1, 1,2,0, 1,0};
        tv[5]  = '{1,0,0,1, 1,5,0, 0,2,0, 0,1};
        tv[6]  = '{1,0,0,1, 1,5,0, 0,3,0, 0,1};
        tv[7]  = '{1,0,0,1, 1,5,0, 0,4,0, 0,1};
        tv[8]  = '{1,0,0,1, 1,5,0, 0,5,0, 0,1};
        tv[9]  = '{1,0,0,1, 1,5,0, 1,5,1, 0,1};
        tv[10] = '{1,1,0,0, 1,5,0, 1,5,0, 0,1};
        for (int i = 0; i < 11; i++) begin
            wi = tv[i].i_w; ri = tv[i].i_r; wy = tv[i].i_wy; ry = tv[i].i_ry;
            tick();
            chk($sformatf("tv%0d_wr_en", i), 32'(w_en[0]), 32'(tv[i].wen));
            chk($sformatf("tv%0d_wr_addr", i), 32'(waddr[0]), tv[i].wa);
            chk($sformatf("tv%0d_wr_done", i), 32'(wdone[0]), 32'(tv[i].wd));
            chk($sformatf("tv%0d_rd_en", i), 32'(r_en[0]), 32'(tv[i].ren));
            chk($sformatf("tv%0d_rd_addr", i), 32'(raddr[0]), tv[i].ra);
            chk($sformatf("tv%0d_rd_done", i), 32'(rdone[0]), 32'(tv[i].rd));
            chk($sformatf("tv%0d_avail", i), 32'(favail[0]), tv[i].fa);
            chk($sformatf("tv%0d_empty", i), 32'(empty_o[0]), 32'(tv[i].emp));
        end
        chk("tv_wr_slot", 32'(wslot[0]), 1);

        // backpressure: wr_rdy alternating
        do_reset();
        wi = 1'b0; wy = 1'b0;
        tick();
        beats = 0; maxa = 0; seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            wy = (c % 2 == 0);
            if (!w_en[0] && wy) beats++;
            prev = int'(waddr[0]);
            tick();
            if (int'(waddr[0]) > maxa) maxa = int'(waddr[0]);
            if (!wy) chk("bp_hold", 32'(waddr[0]), prev);
            if (wdone[0]) begin
                seen = 1'b1;
                break;
            end
        end
        wi = 1'b1;
        chk("bp_done", 32'(seen), 1);
        chk("bp_beats", beats, 4);
        chk("bp_max_addr", maxa, 5);

        // fill with no reader, then a fourth request in both modes
        do_reset();
        for (int k = 0; k < 3; k++) begin
            write_frame(last);
            chk($sformatf("fill%0d_last_addr", k), last, 5 + 4 * k);
        end
        chk("fill_full0", 32'(full_o[0]), 1);
        chk("fill_full1", 32'(full_o[1]), 1);
        chk("fill_avail0", 32'(favail[0]), 3);
        wi = 1'b0; wy = 1'b1;
        tick();
        chk("drop_pulse1", 32'(fdrop[1]), 1);
        chk("drop_pulse0", 32'(fdrop[0]), 0);
        chk("drop_addr1", 32'(waddr[1]), 10);
        chk("drop_avail1", 32'(favail[1]), 2);
        chk("stall_wr_en0", 32'(w_en[0]), 1);
        repeat (4) tick();
        wi = 1'b1;
        chk("drop_done1", 32'(wdone[1]), 1);
        chk("drop_end_addr1", 32'(waddr[1]), 13);
        chk("drop_avail_back1", 32'(favail[1]), 3);
        chk("stall_still0", 32'(w_en[0]), 1);

        // reader busy on slot 0 while slots 1 and 2 complete
        do_reset();
        write_frame(last);
        ri = 1'b0; ry = 1'b0;
        tick();
        chk("busy_rd_en", 32'(r_en[0]), 0);
        chk("busy_rd_slot", 32'(rslot[0]), 0);
        write_frame(last);
        write_frame(last);
        chk("busy_full", 32'(full_o[0]), 1);
        chk("busy_avail", 32'(favail[0]), 2);
        chk("busy_wr_slot", 32'(wslot[0]), 0);
        wi = 1'b0;
        repeat (2) tick();
        chk("busy_stall", 32'(w_en[0]), 1);
        ry = 1'b1; seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (rdone[0]) begin
                seen = 1'b1;
                break;
            end
        end
        chk("busy_rd_done", 32'(seen), 1);
        chk("busy_wr_not_yet", 32'(w_en[0]), 1);
        ri = 1'b1; ry = 1'b0;
        tick();
        chk("freed_wr_en", 32'(w_en[0]), 0);
        chk("freed_wr_addr", 32'(waddr[0]), 2);
        chk("freed_wr_slot", 32'(wslot[0]), 0);
        wi = 1'b1;

        // reset mid-fill at offset 2
        do_reset();
        wi = 1'b0; wy = 1'b1;
        repeat (3) tick();
        chk("mid_addr", 32'(waddr[0]), 4);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_wr_en", 32'(w_en[0]), 1);
        chk("mid_rst_addr", 32'(waddr[0]), 2);
        chk("mid_rst_avail", 32'(favail[0]), 0);
        chk("mid_rst_empty", 32'(empty_o[0]), 1);
        chk("mid_rst_done", 32'(wdone[0]), 0);
        tick();
        reset = 1'b0;
        tick();
        chk("restart_wr_en", 32'(w_en[0]), 0);
        chk("restart_addr", 32'(waddr[0]), 2);
        chk("restart_slot", 32'(wslot[0]), 0);
        wi = 1'b1;

        // randomized traffic with occasional resets
        do_reset();
        for (int c = 0; c < 2000; c++) begin
            wi = ($urandom_range(0, 9) < 3);
            ri = ($urandom_range(0, 9) < 5);
            wy = ($urandom_range(0, 9) < 7);
            ry = ($urandom_range(0, 9) < 6);
            reset = ($urandom_range(0, 399) == 0);
            tick();
        end
        reset = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/frame_buf_ring.md
Name: frame_buf_ring

Overview:
- N-slot frame buffer address controller for the external-memory frame store.
- Generalises the single-buffer writer/reader address generator to NUM_BUFS frame slots in a ring. Whole frames are handed off from writer to reader.
- Optional drop mode lets the camera-side writer never stall.
- Sits between the capture/display pipelines and the memory interface's wr/rd command ports.

Parameters:
- ADDR_WIDTH, 29: memory word address width.
- BASE_ADDR, 2: address of word 0 of slot 0.
- BUF_SIZE, 307200: words per frame slot.
- NUM_BUFS, 3: frame slots; legal range 2..8.
- SLOT_W, 3: slot index width; must satisfy 2^SLOT_W ≥ NUM_BUFS and hold the value NUM_BUFS.
- DROP_MODE, 0: 0 = writer stalls when no slot is free; 1 = writer overwrites the newest unread frame.

Ports:
- clk, in, 1: single clock for all logic.
- reset, in, 1: asynchronous, active-high.
- wr_en_in, in, 1: active-low write request from capture side.
- rd_en_in, in, 1: active-low read request from display side.
- wr_rdy, in, 1: memory accepts a write beat this cycle.
- rd_rdy, in, 1: memory accepts a read beat this cycle.
- wr_en, out, 1: active-low write command, registered.
- rd_en, out, 1: active-low read command, registered.
- wr_addr, out, ADDR_WIDTH: current write word address.
- rd_addr, out, ADDR_WIDTH: current read word address.
- wr_slot, out, SLOT_W: slot the writer fills next or is filling now.
- rd_slot, out, SLOT_W: slot the reader is reading or last read.
- frames_avail, out, SLOT_W: completed, unread frames.
- full, out, 1: high when no slot is free for the writer, i.e. frames_avail + rd_busy == NUM_BUFS.
- empty, out, 1: high when frames_avail == 0.
- wr_frame_done, out, 1: one-cycle pulse on the last write beat of a frame.
- rd_frame_done, out, 1: one-cycle pulse on the last read beat of a frame.
- frame_drop, out, 1: one-cycle pulse when a pending frame is discarded.

Behaviour:
- Reset (async assert, sync release), outputs:
  - wr_en = rd_en = 1 (deasserted);
  - wr_addr = rd_addr = BASE_ADDR;
  - wr_slot = rd_slot = head = 0; frames_avail = 0;
  - full = 0; empty = 1; all pulses 0; both FSMs IDLE; rd_busy = 0.
- Reset mid-frame: partial frame discarded, no pulses.
- Slot base = BASE_ADDR + slot*BUF_SIZE.
- Offset counts 0..BUF_SIZE-1; exactly BUF_SIZE beats per frame (no extra word).
- Beat accepted on an edge with wr_en==0 and wr_rdy==1; same rule for rd_en/rd_rdy.
- Address advances by 1 only on an accepted beat.
- Writer FSM W_IDLE -> W_FILL:
  - Start condition: wr_en_in==0 and a slot is free, i.e. frames_avail + rd_busy < NUM_BUFS.
  - On start: wr_addr <= base(wr_slot), wr_en <= 0.
- Writer no-slot case when wr_en_in==0 in W_IDLE:
  - DROP_MODE=0: stay IDLE.
  - DROP_MODE=1: frame_drop pulse, frames_avail--, wr_slot <= wr_slot-1 mod NUM_BUFS (reuse newest pending slot), then start FILL on the same edge.
- In W_FILL: wr_en <= wr_en_in, except on the last accepted beat.
- Last accepted beat (offset BUF_SIZE-1):
  - wr_en <= 1, wr_frame_done pulse;
  - frames_avail++, wr_slot <= wr_slot+1 mod NUM_BUFS;
  - go to W_IDLE.
- Reader FSM R_IDLE -> R_READ:
  - Start condition: rd_en_in==0 and frames_avail > 0.
  - On start: rd_slot <= head, head <= head+1 mod NUM_BUFS, frames_avail--, rd_busy <= 1, rd_addr <= base(head), rd_en <= 0.
- In R_READ: rd_en <= rd_en_in.
- Reader last accepted beat: rd_en <= 1, rd_frame_done pulse, rd_busy <= 0, go to R_IDLE.
- Simultaneous events:
  - All start/free decisions use pre-edge counts.
  - Writer completion plus reader start on the same edge: frames_avail net unchanged.
  - A slot freed by reader completion becomes usable by the writer the next cycle.
  - Reader start and writer drop on the same edge cannot target the same slot, because full with rd_busy==0 implies frames_avail ≥ 2; the reader takes head, the writer takes the newest.
- Read latency/data are the memory's concern; this block issues addresses only.
- full and empty are registered and consistent with the post-edge counts.

Test Plan (BUF_SIZE=4, NUM_BUFS=3, BASE_ADDR=2):
- Single frame: wr_en_in=0, wr_rdy=1 -> wr_addr 2,3,4,5; wr_frame_done on beat 4; frames_avail=1, wr_slot=1. Then read -> rd_addr 2..5, rd_frame_done, empty=1.
- Backpressure: wr_rdy toggled 1,0,1,0 -> wr_addr holds on 0 cycles; exactly 4 accepted beats; no address beyond 5.
- Fill with no reader, DROP_MODE=0 -> slot bases 2, 6, 10; full=1 after the third frame; the fourth request keeps wr_en=1.
- Same case with DROP_MODE=1 -> fourth frame: frame_drop pulse, rewrites addresses 10..13, frames_avail returns to 3.
- Reader busy on slot 0 while writer completes slots 1 and 2 -> full=1. Reader finishes -> writer starts slot 0 (addr 2) one cycle after rd_frame_done.
- Assert reset mid-FILL at offset 2 -> outputs immediately at reset values; the next frame restarts at addr 2, slot 0.
